// File: rtl/imm_encoder.sv
// imm_encoder: packs RV32I instruction fields and an immediate into a 32-bit
// instruction word (formats R/I/S/B/U/J) and flags immediates that cannot be
// represented. Two-stage valid/ready pipeline: S1 holds the encoded word and
// error flag, S2 is the output register. A saturating counter tracks how many
// errored entries have been delivered downstream.
module imm_encoder #(
  parameter bit CHECK_EN = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic        s1_valid;
  logic [31:0] s1_instr;
  logic        s1_err;

  logic [31:0] enc_instr;
  logic        enc_range_err;
  logic        enc_illegal;
  logic        enc_err;

  logic        s2_free;
  logic        s1_free;
  logic        s1_to_s2;
  logic        accept;

  // A stage can take a new entry when it is empty or its occupant leaves this cycle.
  assign s2_free  = !out_valid || out_ready;
  assign s1_free  = !s1_valid || s2_free;
  assign s1_to_s2 = s1_valid && s2_free;
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Field packing and range check; sign-extension checks require the bits above
  // the encodable range to be all copies of the top encodable bit.
  always_comb begin
    enc_instr     = 32'd0;
    enc_range_err = 1'b0;
    enc_illegal   = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      FMT_I: begin
        enc_instr     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_S: begin
        enc_instr     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_B: begin
        enc_instr     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
        enc_range_err = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      FMT_U: begin
        enc_instr     = {in_imm[31:12], in_rd, in_opcode};
        enc_range_err = |in_imm[11:0];
      end
      FMT_J: begin
        enc_instr     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
        enc_range_err = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      default: begin
        enc_instr   = 32'd0;
        enc_illegal = 1'b1;
      end
    endcase
    // Illegal formats are always flagged; range errors only when checking is enabled.
    enc_err = enc_illegal || (CHECK_EN && enc_range_err);
  end

  // Stage 1: capture the encoded word on accept, drain into stage 2 when it frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_instr <= 32'd0;
      s1_err   <= 1'b0;
    end else if (s1_free) begin
      s1_valid <= accept;
      if (accept) begin
        s1_instr <= enc_instr;
        s1_err   <= enc_err;
      end
    end
  end

  // Stage 2 (output register): held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_to_s2;
      if (s1_to_s2) begin
        out_instr <= s1_instr;
        out_err   <= s1_err;
      end
    end
  end

  // Saturating count of errored entries consumed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder: a vector table of encodings/range cases,
// followed by backpressure and mid-operation reset sequences. A second instance
// with range checking disabled and a 1-bit counter runs in lockstep.
module tb_imm_encoder;

  localparam int CNT_W  = 16;
  localparam int CNT_W2 = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_ready;

  logic              in_ready_a, out_valid_a, out_err_a;
  logic [31:0]       out_instr_a;
  logic [CNT_W-1:0]  err_cnt_a;
  logic              in_ready_b, out_valid_b, out_err_b;
  logic [31:0]       out_instr_b;
  logic [CNT_W2-1:0] err_cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CHECK_EN(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_instr(out_instr_a),
    .out_err(out_err_a), .err_cnt(err_cnt_a)
  );

  imm_encoder #(.CHECK_EN(1'b0), .CNT_W(CNT_W2)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_instr(out_instr_b),
    .out_err(out_err_b), .err_cnt(err_cnt_b)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;     // CHECK_EN=1
    logic        exp_err_nc;  // CHECK_EN=0
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_funct3 = v.f3;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  initial begin
    int exp_cnt_a;
    int exp_cnt_b;
    int lat;
    int idx;
    int ngot;
    logic rdy;
    logic [31:0] held;
    logic held_set;
    logic [31:0] got[4];
    vec_t bp[4];
    logic seen_out;

    //          fmt op     rd     f3 rs1 rs2 f7     imm            instr          e  e_nc
    vecs[0]  = '{3'd1, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0, 1'b0};
    vecs[1]  = '{3'd4, 7'h37, 5'd5,  3'd0, 5'd0, 5'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0, 1'b0};
    vecs[2]  = '{3'd4, 7'h37, 5'd5,  3'd0, 5'd0, 5'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b1, 1'b0};
    vecs[3]  = '{3'd5, 7'h6F, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000008, 32'h008000EF, 1'b0, 1'b0};
    vecs[4]  = '{3'd3, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0, 1'b0};
    vecs[5]  = '{3'd1, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1, 1'b0};
    vecs[6]  = '{3'd7, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
    vecs[7]  = '{3'd0, 7'h33, 5'd3,  3'd0, 5'd1, 5'd2, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0, 1'b0};
    vecs[8]  = '{3'd0, 7'h33, 5'd3,  3'd0, 5'd1, 5'd2, 7'h20, 32'h00000000, 32'h402081B3, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'h00, 32'h00000008, 32'h0020A423, 1'b0, 1'b0};
    vecs[10] = '{3'd2, 7'h23, 5'd0,  3'd2, 5'd1, 5'd2, 7'h00, 32'hFFFFF800, 32'h8020A023, 1'b0, 1'b0};
    vecs[11] = '{3'd3, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000005, 32'h00000263, 1'b1, 1'b0};
    vecs[12] = '{3'd5, 7'h6F, 5'd0,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1, 1'b0};
    vecs[13] = '{3'd3, 7'h63, 5'd0,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000FFE, 32'h7E000FE3, 1'b0, 1'b0};
    vecs[14] = '{3'd6, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'h00000005, 32'h00000000, 1'b1, 1'b1};
    vecs[15] = '{3'd1, 7'h13, 5'd1,  3'd0, 5'd0, 5'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0, 1'b0};

    for (int k = 0; k < 4; k++) begin
      bp[k] = '{3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00, 32'(k + 1),
                (32'(k + 1) << 20) | 32'h00000093, 1'b0, 1'b0};
    end

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_out_instr", out_instr_a, 32'd0);
    check("rst_out_err", 32'(out_err_a), 32'd0);
    check("rst_err_cnt", 32'(err_cnt_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);

    // Vector table: one request at a time, out_ready held high
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready_a), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 6) begin
        @(negedge clk);
        lat++;
        if (out_valid_a) break;
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_instr", i), out_instr_a, vecs[i].exp_instr);
      check($sformatf("v%0d_err", i), 32'(out_err_a), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_nc_instr", i), out_instr_b, vecs[i].exp_instr);
      check($sformatf("v%0d_nc_err", i), 32'(out_err_b), 32'(vecs[i].exp_err_nc));
      if (vecs[i].exp_err) exp_cnt_a++;
      if (vecs[i].exp_err_nc && exp_cnt_b < (1 << CNT_W2) - 1) exp_cnt_b++;
      @(negedge clk);
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt_a), 32'(exp_cnt_a));
      check($sformatf("v%0d_nc_err_cnt", i), 32'(err_cnt_b), 32'(exp_cnt_b));
      $display("vec %0d fmt=%0d imm=0x%08h instr=0x%08h err=%0b err_cnt=%0d",
               i, vecs[i].fmt, vecs[i].imm, out_instr_a, out_err_a, err_cnt_a);
    end

    // Backpressure: 4 back-to-back requests, out_ready low for 5 cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0; ngot = 0; held_set = 1'b0; held = 32'd0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) out_ready = 1'b1;
      if (idx < 4) begin
        drive(bp[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      rdy = in_ready_a;
      if (!out_ready && out_valid_a) begin
        if (held_set) check("bp_hold_instr", out_instr_a, held);
        else begin
          held = out_instr_a;
          held_set = 1'b1;
        end
      end
      if (c == 4) begin
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_in_ready_low", 32'(in_ready_a), 32'd0);
      end
      if (out_valid_a && out_ready && ngot < 4) begin
        got[ngot] = out_instr_a;
        ngot++;
        $display("bp deliver %0d instr=0x%08h", ngot - 1, out_instr_a);
      end
      @(posedge clk);
      if (in_valid && rdy) idx++;
      #1;
      if (ngot == 4 && idx == 4) break;
    end
    in_valid = 1'b0;
    check("bp_held_word", held, bp[0].exp_instr);
    check("bp_delivered", 32'(ngot), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_order%0d", k), (k < ngot) ? got[k] : 32'hXXXXXXXX, bp[k].exp_instr);
    end
    @(negedge clk);
    check("bp_no_dup", 32'(out_valid_a), 32'd0);

    // Mid-operation reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6 && idx < 2; c++) begin
      drive(vecs[5]);
      in_valid = 1'b1;
      @(negedge clk);
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) idx++;
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rs_full_in_ready", 32'(in_ready_a), 32'd0);
    check("rs_full_out_valid", 32'(out_valid_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_out_valid", 32'(out_valid_a), 32'd0);
    check("rs_out_instr", out_instr_a, 32'd0);
    check("rs_out_err", 32'(out_err_a), 32'd0);
    check("rs_err_cnt", 32'(err_cnt_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid_a) seen_out = 1'b1;
    end
    check("rs_no_ghost_output", 32'(seen_out), 32'd0);
    check("rs_in_ready", 32'(in_ready_a), 32'd1);
    check("rs_err_cnt_after", 32'(err_cnt_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
